// File: rtl/cdma_pkg.sv
// cdma_pkg: shared state encoding, default widths and descriptor type for the cube sequencer
package cdma_pkg;
  localparam int ADDR_W = 32;
  localparam int CUBE_W = 8;
  localparam int STRIDE_W = 16;
  localparam int LEN_W = 16;
  localparam int ELEM_B = 4;
  localparam int MAX_OUT = 4;
  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DRAIN} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0]   src_base;
    logic [ADDR_W-1:0]   dst_base;
    logic [CUBE_W-1:0]   channel;
    logic [CUBE_W-1:0]   row;
    logic [CUBE_W-1:0]   col;
    logic [STRIDE_W-1:0] src_row_str;
    logic [STRIDE_W-1:0] src_ch_str;
    logic [STRIDE_W-1:0] dst_row_str;
    logic [STRIDE_W-1:0] dst_ch_str;
  } desc_t;
endpackage

// File: rtl/cdma_stride_walker.sv
// cdma_stride_walker: row/channel position counters with incremental src/dst pointers for the next burst
module cdma_stride_walker
  import cdma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  desc_t             desc,
  output logic [ADDR_W-1:0] src_next,
  output logic [ADDR_W-1:0] dst_next,
  output logic              last
);
  logic [CUBE_W-1:0] rows, chans, row_cnt, ch_cnt;
  logic [STRIDE_W-1:0] srs, scs, drs, dcs;
  logic [ADDR_W-1:0] src_row, src_ch, dst_row, dst_ch;
  logic wrap;
  // Pointers track the burst currently held in the parent's cmd register
  assign wrap = row_cnt == rows - CUBE_W'(1);
  assign last = wrap && ch_cnt == chans - CUBE_W'(1);
  assign src_next = wrap ? src_ch + ADDR_W'(scs) : src_row + ADDR_W'(srs);
  assign dst_next = wrap ? dst_ch + ADDR_W'(dcs) : dst_row + ADDR_W'(drs);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows <= '0;
      chans <= '0;
      row_cnt <= '0;
      ch_cnt <= '0;
      {srs, scs, drs, dcs} <= '0;
      {src_row, src_ch, dst_row, dst_ch} <= '0;
    end else if (load) begin
      rows <= desc.row;
      chans <= desc.channel;
      row_cnt <= '0;
      ch_cnt <= '0;
      {srs, scs, drs, dcs} <= {desc.src_row_str, desc.src_ch_str, desc.dst_row_str, desc.dst_ch_str};
      {src_row, src_ch} <= {desc.src_base, desc.src_base};
      {dst_row, dst_ch} <= {desc.dst_base, desc.dst_base};
    end else if (step) begin
      src_row <= src_next;
      dst_row <= dst_next;
      if (wrap) begin
        row_cnt <= '0;
        ch_cnt <= ch_cnt + CUBE_W'(1);
        src_ch <= src_next;
        dst_ch <= dst_next;
      end else begin
        row_cnt <= row_cnt + CUBE_W'(1);
      end
    end
  end
endmodule

// File: rtl/cdma_cube_agen.sv
// cdma_cube_agen: splits a channel x row x col cube descriptor into credit-limited row-burst commands
module cdma_cube_agen
  import cdma_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int CUBE_WIDTH = CUBE_W,
  parameter int STRIDE_WIDTH = STRIDE_W,
  parameter int ELEM_BYTES = ELEM_B,
  parameter int LEN_WIDTH = LEN_W,
  parameter int MAX_OUTSTANDING = MAX_OUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [ADDR_WIDTH-1:0]   cfg_src_base,
  input  logic [ADDR_WIDTH-1:0]   cfg_dst_base,
  input  logic [CUBE_WIDTH-1:0]   cfg_channel,
  input  logic [CUBE_WIDTH-1:0]   cfg_row,
  input  logic [CUBE_WIDTH-1:0]   cfg_col,
  input  logic [STRIDE_WIDTH-1:0] cfg_src_row_str,
  input  logic [STRIDE_WIDTH-1:0] cfg_src_ch_str,
  input  logic [STRIDE_WIDTH-1:0] cfg_dst_row_str,
  input  logic [STRIDE_WIDTH-1:0] cfg_dst_ch_str,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [ADDR_WIDTH-1:0]   cmd_src_addr,
  output logic [ADDR_WIDTH-1:0]   cmd_dst_addr,
  output logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    cmd_done,
  output logic                    busy,
  output logic                    transfer_done,
  output logic                    err
);
  state_t state;
  desc_t shadow;
  logic shadow_full, cfg_fire, fire, done_ok, zero_dim, cmd_free, step, walk_last;
  logic [3:0] outstanding, out_next;
  logic [ADDR_WIDTH-1:0] walk_src, walk_dst;
  assign cfg_ready = !shadow_full;
  assign cfg_fire = cfg_valid && cfg_ready;
  assign fire = cmd_valid && cmd_ready;
  // A done with nothing outstanding only counts if a fire covers it in the same cycle
  assign done_ok = cmd_done && (outstanding != 4'd0 || fire);
  assign out_next = outstanding + 4'(fire) - 4'(done_ok);
  assign busy = state != IDLE;
  assign zero_dim = shadow.channel == '0 || shadow.row == '0 || shadow.col == '0;
  assign cmd_free = !cmd_valid || fire;
  assign step = state == ISSUE && cmd_free && !walk_last && out_next < 4'(MAX_OUTSTANDING);
  cdma_stride_walker u_walker (
    .clk(clk), .rst(rst), .load(state == LOAD), .step(step), .desc(shadow),
    .src_next(walk_src), .dst_next(walk_dst), .last(walk_last)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shadow <= '0;
      shadow_full <= 1'b0;
      outstanding <= '0;
      cmd_valid <= 1'b0;
      cmd_src_addr <= '0;
      cmd_dst_addr <= '0;
      cmd_len <= '0;
      transfer_done <= 1'b0;
      err <= 1'b0;
    end else begin
      transfer_done <= 1'b0;
      outstanding <= out_next;
      if (cmd_done && outstanding == 4'd0 && !fire) err <= 1'b1;
      if (cfg_fire) begin
        shadow_full <= 1'b1;
        shadow <= '{cfg_src_base, cfg_dst_base, cfg_channel, cfg_row, cfg_col,
                    cfg_src_row_str, cfg_src_ch_str, cfg_dst_row_str, cfg_dst_ch_str};
      end else if (state == LOAD) begin
        shadow_full <= 1'b0;
      end
      case (state)
        IDLE: if (shadow_full || cfg_fire) state <= LOAD;
        LOAD: begin
          state <= zero_dim ? DRAIN : ISSUE;
          cmd_valid <= !zero_dim;
          cmd_src_addr <= shadow.src_base;
          cmd_dst_addr <= shadow.dst_base;
          cmd_len <= LEN_WIDTH'(shadow.col) * LEN_WIDTH'(ELEM_BYTES);
        end
        ISSUE: begin
          if (fire && walk_last) begin
            state <= DRAIN;
            cmd_valid <= 1'b0;
          end else if (step) begin
            cmd_valid <= 1'b1;
            cmd_src_addr <= walk_src;
            cmd_dst_addr <= walk_dst;
          end else if (fire) begin
            cmd_valid <= 1'b0;
          end
        end
        DRAIN: if (outstanding == 4'd0) begin
          transfer_done <= 1'b1;
          state <= shadow_full ? LOAD : IDLE;
        end
      endcase
    end
  end
endmodule
